banked_datapath: RTL
====================

BANKED_DATAPATH -- requirements
Module: banked_datapath

Interface
REQ-001 Parameter WIDTH, default 4: data, accumulator and register width in bits.
REQ-002 Parameter NREGS, default 16: registers per bank; even and a power of two; IDXW = log2(NREGS).
REQ-003 Parameter NBANKS, default 2: register banks; a power of two; BW = max(1, log2(NBANKS)).
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 data  input  WIDTH  external bus value for register writes.
REQ-007 inst_operand  input  IDXW  register index, immediate, or branch condition field.
REQ-008 alu_op  input  2  operation code: 0 ADD, 1 SUB, 2 INC-reg, 3 DEC-acc.
REQ-009 acc_input_sel  input  3  accumulator source: 0 reg, 1 ALU, 2 immediate, 3 carry, 4 carry?10:9.
REQ-010 write_accumulator / clear_accumulator / write_carry / clear_carry  input  1 each  accumulator and carry strobes.
REQ-011 reg_input_sel  input  2  register source: 0 acc, 1 ALU, 2 data.
REQ-012 write_register  input  1  write the selected register.
REQ-013 write_bank  input  1  load the bank register from inst_operand[BW-1:0].
REQ-014 pair_wr_start  input  1  start a two-cycle register-pair write.
REQ-015 pair_data  input  2*WIDTH  pair value, captured on start.
REQ-016 daa  input  1  decimal-adjust-accumulator strobe.
REQ-017 test  input  1  external branch test line, active-high.
REQ-018 regval  output  WIDTH  selected register, combinational.
REQ-019 pair_rd  output  2*WIDTH  {reg[2p], reg[2p+1]} with p = inst_operand[IDXW-1:1], current bank.
REQ-020 acc  output  WIDTH  accumulator.
REQ-021 carry_out  output  1  carry flag.
REQ-022 bank  output  BW  current bank.
REQ-023 pair_busy  output  1  high while a pair write is in progress.
REQ-024 pair_done  output  1  one-cycle pulse on the cycle after the second pair write.
REQ-025 take_branch  output  1  branch decision, combinational.

Function
REQ-026 The effective register address SHALL be {bank, inst_operand}.
REQ-027 The ALU SHALL compute a WIDTH+1-bit result: ADD = acc+reg+carry; SUB = acc+~reg+~carry; INC = reg+1; DEC = acc+{WIDTH{1}}. Bit WIDTH is the carry input.
REQ-028 Priority: clear_carry over write_carry; clear_accumulator over daa over write_accumulator.
REQ-029 The pair sequencer SHALL have states IDLE, WR_HI and WR_LO.
REQ-030 IDLE->WR_HI on pair_wr_start, latching pair_data, the pair index and the bank.
REQ-031 WR_HI writes the high half to reg[2p]; WR_LO writes the low half to reg[2p+1]; then the sequencer returns to IDLE and pulses pair_done.
REQ-032 pair_busy SHALL be high in WR_HI and WR_LO.
REQ-033 pair_wr_start while busy SHALL be ignored.
REQ-034 write_register while busy SHALL be ignored.
REQ-035 write_bank during a pair write SHALL not affect that pair's target bank.
REQ-036 take_branch = inst_operand[3] XOR ((op[0]&test)|(op[1]&carry)|(op[2]&acc==0)).
REQ-037 If IDXW<4, take_branch SHALL be 0.
REQ-038 A write_bank value of NBANKS or greater SHALL wrap modulo NBANKS.

Reset
REQ-039 On reset: acc=0, carry=1, all registers in all banks=0, bank=0, sequencer IDLE, pair_busy=0, pair_done=0.
REQ-040 Reset during a pair write SHALL abort it; a register not yet written keeps its reset value.

Configuration
REQ-041 With BANKED_DATAPATH_DAA_EN defined, daa SHALL apply when WIDTH==4 and (acc>9 or carry==1): acc <= acc+6 mod 16, with carry set to 1 on overflow past 15 and otherwise unchanged.
REQ-042 Without BANKED_DATAPATH_DAA_EN, or with WIDTH!=4, daa SHALL be ignored.

Verification
REQ-043 After reset: acc=0, carry=1, bank=0, regval=0 for every index, pair_busy=0.
REQ-044 Pair write: pair_wr_start with pair_data=0xA5, operand=4 -> pair_busy high for 2 cycles, reg4=A, reg5=5, pair_done pulses once, pair_rd=0xA5.
REQ-045 Banking: write reg3=7 in bank 0, write_bank 1, write reg3=2 -> regval=2; write_bank 0 -> regval=7.
REQ-046 DAA (macro on): acc=0xC, carry=0, daa -> acc=2, carry=1; acc=5, carry=0 -> unchanged. With macro off: acc unchanged.
REQ-047 Branch: acc=0, operand=0x4 -> take_branch=1; operand=0xC -> 0; test=1, operand=0x1 -> 1.
REQ-048 Conflict: write_register to reg5 during WR_HI -> ignored; reset in WR_HI -> reg4 and reg5 both 0, pair_busy=0.

Source files
------------

// File: rtl/banked_datapath_if.sv
// Bus bundle for banked_datapath: control strobes, operands and datapath observation outputs.
// The master side drives the control inputs; the slave side is the datapath.
interface banked_datapath_if #(
  parameter int WIDTH  = 4,
  parameter int NREGS  = 16,
  parameter int NBANKS = 2
);
  localparam int IDXW = $clog2(NREGS);
  localparam int BW   = (NBANKS > 1) ? $clog2(NBANKS) : 1;

  logic [WIDTH-1:0]   data;
  logic [IDXW-1:0]    inst_operand;
  logic [1:0]         alu_op;
  logic [2:0]         acc_input_sel;
  logic               write_accumulator;
  logic               clear_accumulator;
  logic               write_carry;
  logic               clear_carry;
  logic [1:0]         reg_input_sel;
  logic               write_register;
  logic               write_bank;
  logic               pair_wr_start;
  logic [2*WIDTH-1:0] pair_data;
  logic               daa;
  logic               test;

  logic [WIDTH-1:0]   regval;
  logic [2*WIDTH-1:0] pair_rd;
  logic [WIDTH-1:0]   acc;
  logic               carry_out;
  logic [BW-1:0]      bank;
  logic               pair_busy;
  logic               pair_done;
  logic               take_branch;

  modport master (
    output data, inst_operand, alu_op, acc_input_sel,
           write_accumulator, clear_accumulator, write_carry, clear_carry,
           reg_input_sel, write_register, write_bank,
           pair_wr_start, pair_data, daa, test,
    input  regval, pair_rd, acc, carry_out, bank, pair_busy, pair_done, take_branch
  );

  modport slave (
    input  data, inst_operand, alu_op, acc_input_sel,
           write_accumulator, clear_accumulator, write_carry, clear_carry,
           reg_input_sel, write_register, write_bank,
           pair_wr_start, pair_data, daa, test,
    output regval, pair_rd, acc, carry_out, bank, pair_busy, pair_done, take_branch
  );
endinterface

// File: rtl/banked_datapath.sv
// Banked register file + accumulator/carry ALU datapath with a two-cycle register-pair writer.
// Optional decimal adjust enabled by defining BANKED_DATAPATH_DAA_EN (only effective for WIDTH==4).
module banked_datapath #(
  parameter int WIDTH  = 4,
  parameter int NREGS  = 16,
  parameter int NBANKS = 2
) (
  input  logic             clock,
  input  logic             reset,
  banked_datapath_if.slave bus
);
  localparam int IDXW  = $clog2(NREGS);
  localparam int BW    = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int AW    = BW + IDXW;
  localparam int DEPTH = (2**BW) * NREGS;
  localparam int W1    = WIDTH + 1;

`ifdef BANKED_DATAPATH_DAA_EN
  localparam bit DAA_EN = (WIDTH == 4);
`else
  localparam bit DAA_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WR_HI, WR_LO} pair_state_e;

  pair_state_e        state_q, state_d;
  logic [2*WIDTH-1:0] pair_val_q, pair_val_d;
  logic [IDXW-2:0]    pair_idx_q, pair_idx_d;
  logic [BW-1:0]      pair_bank_q, pair_bank_d;
  logic               pair_done_q, pair_done_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [BW-1:0]      bank_q, bank_d;
  logic [WIDTH-1:0]   regs_q [DEPTH];
  logic [WIDTH-1:0]   regs_d [DEPTH];

  logic [AW-1:0]      rd_addr, prd_hi_addr, prd_lo_addr, wr_hi_addr, wr_lo_addr;
  logic [WIDTH-1:0]   reg_sel, acc_src, reg_in;
  logic [WIDTH:0]     alu_res, daa_sum;
  logic               busy, ncarry, daa_hit;

  assign rd_addr     = {bank_q, bus.inst_operand};
  assign prd_hi_addr = {bank_q, bus.inst_operand[IDXW-1:1], 1'b0};
  assign prd_lo_addr = {bank_q, bus.inst_operand[IDXW-1:1], 1'b1};
  // Pair writes target the bank/index captured at start, not the live ones.
  assign wr_hi_addr  = {pair_bank_q, pair_idx_q, 1'b0};
  assign wr_lo_addr  = {pair_bank_q, pair_idx_q, 1'b1};

  assign busy    = (state_q != IDLE);
  assign reg_sel = regs_q[rd_addr];
  assign ncarry  = ~carry_q;

  always_comb begin
    alu_res = '0;
    unique case (bus.alu_op)
      2'd0:    alu_res = {1'b0, acc_q} + {1'b0, reg_sel} + {{WIDTH{1'b0}}, carry_q};
      2'd1:    alu_res = {1'b0, acc_q} + {1'b0, ~reg_sel} + {{WIDTH{1'b0}}, ncarry};
      2'd2:    alu_res = {1'b0, reg_sel} + W1'(1);
      default: alu_res = {1'b0, acc_q} + {1'b0, {WIDTH{1'b1}}};
    endcase
  end

  always_comb begin
    acc_src = '0;
    case (bus.acc_input_sel)
      3'd0:    acc_src = reg_sel;
      3'd1:    acc_src = alu_res[WIDTH-1:0];
      3'd2:    acc_src = WIDTH'(bus.inst_operand);
      3'd3:    acc_src[0] = carry_q;
      3'd4:    acc_src = carry_q ? WIDTH'(10) : WIDTH'(9);
      default: acc_src = '0;
    endcase
  end

  always_comb begin
    reg_in = bus.data;
    case (bus.reg_input_sel)
      2'd0:    reg_in = acc_q;
      2'd1:    reg_in = alu_res[WIDTH-1:0];
      default: reg_in = bus.data;
    endcase
  end

  assign daa_sum = {1'b0, acc_q} + W1'(6);
  assign daa_hit = DAA_EN && bus.daa && ((acc_q > WIDTH'(9)) || carry_q);

  // Pair sequencer: next state and capture
  always_comb begin
    state_d     = state_q;
    pair_val_d  = pair_val_q;
    pair_idx_d  = pair_idx_q;
    pair_bank_d = pair_bank_q;
    pair_done_d = 1'b0;
    unique case (state_q)
      IDLE: if (bus.pair_wr_start) begin
        state_d     = WR_HI;
        pair_val_d  = bus.pair_data;
        pair_idx_d  = bus.inst_operand[IDXW-1:1];
        pair_bank_d = bank_q;
      end
      WR_HI: state_d = WR_LO;
      WR_LO: begin
        state_d     = IDLE;
        pair_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Accumulator, carry, bank and register file next values
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    bank_d  = bank_q;
    regs_d  = regs_q;

    if (bus.clear_accumulator) acc_d = '0;
    else if (daa_hit) begin
      acc_d = daa_sum[WIDTH-1:0];
      if (daa_sum[WIDTH]) carry_d = 1'b1;
    end
    else if (bus.write_accumulator) acc_d = acc_src;

    if (bus.clear_carry)      carry_d = 1'b0;
    else if (bus.write_carry) carry_d = alu_res[WIDTH];

    if (bus.write_bank) bank_d = bus.inst_operand[BW-1:0] & BW'(NBANKS - 1);

    case (state_q)
      WR_HI:   regs_d[wr_hi_addr] = pair_val_q[2*WIDTH-1:WIDTH];
      WR_LO:   regs_d[wr_lo_addr] = pair_val_q[WIDTH-1:0];
      default: if (bus.write_register) regs_d[rd_addr] = reg_in;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pair_val_q  <= '0;
      pair_idx_q  <= '0;
      pair_bank_q <= '0;
      pair_done_q <= 1'b0;
      acc_q       <= '0;
      carry_q     <= 1'b1;
      bank_q      <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      pair_val_q  <= pair_val_d;
      pair_idx_q  <= pair_idx_d;
      pair_bank_q <= pair_bank_d;
      pair_done_q <= pair_done_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      bank_q      <= bank_d;
      regs_q      <= regs_d;
    end
  end

  // Branch condition needs operand bits [3:0]; narrower operands never branch.
  generate
    if (IDXW >= 4) begin : g_branch
      logic [3:0] cond;
      assign cond = bus.inst_operand[3:0];
      assign bus.take_branch = cond[3] ^ ((cond[0] & bus.test) |
                                          (cond[1] & carry_q) |
                                          (cond[2] & (acc_q == '0)));
    end else begin : g_no_branch
      assign bus.take_branch = 1'b0;
    end
  endgenerate

  assign bus.regval    = reg_sel;
  assign bus.pair_rd   = {regs_q[prd_hi_addr], regs_q[prd_lo_addr]};
  assign bus.acc       = acc_q;
  assign bus.carry_out = carry_q;
  assign bus.bank      = bank_q;
  assign bus.pair_busy = busy;
  assign bus.pair_done = pair_done_q;
endmodule
